pixel_readout: RTL and testbench
================================

Name: pixel_readout

Overview:
Pixel-array/ADC side of the camera control interface. Consumes expose/erase/nre1/nre2/adc strobes from the camera controller and samples adc_data while a row is selected. Buffers both amplifier rows of one frame and streams them to the downstream image path over a valid/ready handshake. Also measures the actual exposure length and flags protocol violations.

Parameters:
DATA_W, 8, ADC sample width in bits
NUM_SAMPLES, 5, samples per row; one sample per clk with adc=1
EXP_W, 5, exposure-length counter width; saturating

Ports:
clk  in  1  system clock; 1 ms period
reset  in  1  synchronous, active-low reset
erase  in  1  pixel erase strobe from controller
expose  in  1  exposure active from controller
nre1  in  1  row 1 select, active low
nre2  in  1  row 2 select, active low
adc  in  1  ADC sample enable
adc_data  in  DATA_W  ADC conversion result
pix_data  out  DATA_W  streamed pixel
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accept
pix_last  out  1  final pixel of frame; qualified by pix_valid
exp_cycles  out  EXP_W  measured length of last exposure
frame_done  out  1  one-cycle pulse after the last pixel is accepted
err  out  1  sticky protocol error; cleared only by reset

Behaviour:
- Reset (reset=0 at posedge clk) has priority over all other inputs. It forces: state IDLE; pix_valid=0, pix_last=0, pix_data=0, exp_cycles=0, frame_done=0, err=0; all counters and pointers 0. Buffer contents are don't-care.
- Buffer: 2*NUM_SAMPLES entries. Row 1 occupies entries 0..NUM_SAMPLES-1; row 2 occupies NUM_SAMPLES..2*NUM_SAMPLES-1.
- A sample is valid when adc=1 and exactly one of nre1/nre2 is 0.
- States:
  - IDLE: wait for expose=1 -> EXPOSE. Clear the exposure counter to 1 on entry.
  - EXPOSE: counter +1 per cycle while expose=1, saturating at 2^EXP_W-1. On the first cycle with expose=0: latch exp_cycles from the counter and go to WAIT_ROW1.
  - WAIT_ROW1: first valid sample with nre1=0 -> write entry 0 and go to ROW1 (count=1).
  - ROW1: each valid nre1 sample writes the next entry. When adc=0, go to WAIT_ROW2.
  - WAIT_ROW2 / ROW2: same as ROW1 for nre2, writing entries starting at NUM_SAMPLES. When adc=0, go to DRAIN.
  - DRAIN: stream entries 0..2*NUM_SAMPLES-1 in order. Return to IDLE after the last pixel is accepted.
- Short row (fewer than NUM_SAMPLES samples): the missing entries are written 0 and err is set.
- Long row (more than NUM_SAMPLES samples): the excess samples are dropped and err is set.
- erase=1 in WAIT_ROW1, ROW1, WAIT_ROW2 or ROW2 aborts the frame: return to IDLE, set err, emit no output.
- Additional err conditions:
  - nre1=0 and nre2=0 in the same cycle; the sample is not written.
  - adc=1 with both nre high outside IDLE/EXPOSE.
  - An nre2 sample while waiting for row 1.
  - expose=1 while in DRAIN; the new frame is ignored until DRAIN ends.
  - expose=1 while in WAIT_ROW1, ROW1, WAIT_ROW2 or ROW2.
- Handshake:
  - pix_valid rises on the first cycle of DRAIN.
  - pix_data and pix_last stay stable while pix_valid=1 and pix_ready=0.
  - A transfer occurs on any cycle with pix_valid=1 and pix_ready=1; the next entry appears the following cycle.
  - Throughput is one pixel per clk under continuous pix_ready=1.
  - pix_last=1 only with entry 2*NUM_SAMPLES-1.
  - frame_done pulses for exactly one cycle, the cycle after the last transfer, coincident with pix_valid returning to 0.
- Latency: the first pixel is valid 1 cycle after ROW2 ends (the cycle adc falls to 0 is seen).
- exp_cycles holds its value until the next exposure ends.

Test Plan:
1. Nominal frame: expose=1 for 15 cycles; row1 samples 1..5 (nre1=0); one idle cycle; row2 samples 6..10 (nre2=0); pix_ready=1 -> exp_cycles=15; pix_data sequence 1..10; pix_last on 10; frame_done one cycle later; err=0.
2. Backpressure: as test 1, with pix_ready toggling 1,0,0,1,... -> each pixel held stable while stalled; order 1..10 preserved; no duplicates or losses.
3. Short/long rows: row1 has 3 samples (A,B,C); row2 has 7 samples -> output A,B,C,0,0 followed by the first 5 row2 samples; err=1.
4. Violations: nre1=0 and nre2=0 with adc=1 -> err=1, sample not stored. In a separate run, erase=1 during ROW1 -> state IDLE, pix_valid stays 0.
5. Exposure saturation and reset: expose=1 for 40 cycles -> exp_cycles=31. Assert reset=0 mid-DRAIN -> next cycle pix_valid=0, exp_cycles=0, err=0.
6. Back-to-back frames: a second expose starts during DRAIN -> err=1, second frame ignored. A third frame started after frame_done -> captured normally.

Source files
------------

// File: rtl/pixel_readout_if.sv
// Pixel stream from the readout buffer to the downstream image path.
interface pixel_readout_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;

   modport master (
      output pix_data,
      output pix_valid,
      output pix_last,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      input  pix_last,
      output pix_ready
   );
endinterface

// File: rtl/pixel_readout.sv
// Pixel-array readout: measures exposure, captures two amplifier rows from the ADC into a
// frame buffer, then streams the buffer out over a valid/ready handshake.
module pixel_readout #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned NUM_SAMPLES = 5,
   parameter int unsigned EXP_W       = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              erase,
   input  logic              expose,
   input  logic              nre1,
   input  logic              nre2,
   input  logic              adc,
   input  logic [DATA_W-1:0] adc_data,
   pixel_readout_if.master   pix,
   output logic [EXP_W-1:0]  exp_cycles,
   output logic              frame_done,
   output logic              err
);
   localparam int unsigned DEPTH = 2 * NUM_SAMPLES;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] ROW2_BASE = PTR_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] ROW_LEN   = CNT_W'(NUM_SAMPLES);

   typedef enum logic [2:0] {
      StIdle, StExpose, StWaitRow1, StRow1, StWaitRow2, StRow2, StDrain
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [EXP_W-1:0]  exp_cnt_q, exp_cnt_d;
   logic [EXP_W-1:0]  exp_cycles_q, exp_cycles_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic             row1_smp, row2_smp, both_low, stray_adc, in_row, xfer, last_xfer;
   logic             wr_en, clr_buf;
   logic [PTR_W-1:0] wr_addr;

   // A sample counts only when exactly one row select is active.
   assign both_low  = ~nre1 & ~nre2;
   assign row1_smp  = adc & ~nre1 & nre2;
   assign row2_smp  = adc & nre1 & ~nre2;
   assign stray_adc = adc & nre1 & nre2 & ~(state_q inside {StIdle, StExpose});
   assign in_row    = state_q inside {StWaitRow1, StRow1, StWaitRow2, StRow2};
   assign xfer      = (state_q == StDrain) & pix.pix_ready;
   assign last_xfer = xfer & (rd_q == LAST_PTR);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; erase aborts any capture phase.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (expose) state_d = StExpose;
         StExpose:   if (!expose) state_d = StWaitRow1;
         StWaitRow1: if (erase) state_d = StIdle; else if (row1_smp) state_d = StRow1;
         StRow1:     if (erase) state_d = StIdle; else if (!adc) state_d = StWaitRow2;
         StWaitRow2: if (erase) state_d = StIdle; else if (row2_smp) state_d = StRow2;
         StRow2:     if (erase) state_d = StIdle; else if (!adc) state_d = StDrain;
         StDrain:    if (last_xfer) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Datapath next-state: exposure counter, row counter, buffer writes, read pointer, err.
   always_comb begin
      cnt_d        = cnt_q;
      rd_d         = rd_q;
      exp_cnt_d    = exp_cnt_q;
      exp_cycles_d = exp_cycles_q;
      wr_en        = 1'b0;
      wr_addr      = '0;
      clr_buf      = 1'b0;
      done_d       = last_xfer;
      err_d        = err_q | both_low | stray_adc | (in_row & (erase | expose))
                   | ((state_q == StDrain) & expose) | ((state_q == StWaitRow1) & row2_smp);
      unique case (state_q)
         StIdle: begin
            rd_d = '0;
            if (expose) exp_cnt_d = EXP_W'(1);
         end
         StExpose: begin
            if (expose) begin
               if (exp_cnt_q != '1) exp_cnt_d = exp_cnt_q + 1'b1;
            end else begin
               exp_cycles_d = exp_cnt_q;
               // Pre-zero the buffer so short rows read back as 0.
               clr_buf      = 1'b1;
            end
         end
         StWaitRow1: begin
            if (!erase && row1_smp) begin
               wr_en = 1'b1;
               cnt_d = CNT_W'(1);
            end
         end
         StRow1: begin
            if (!erase) begin
               if (row1_smp) begin
                  if (cnt_q < ROW_LEN) begin
                     wr_en   = 1'b1;
                     wr_addr = PTR_W'(cnt_q);
                     cnt_d   = cnt_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (!adc && cnt_q < ROW_LEN) begin
                  err_d = 1'b1;
               end
            end
         end
         StWaitRow2: begin
            if (!erase && row2_smp) begin
               wr_en   = 1'b1;
               wr_addr = ROW2_BASE;
               cnt_d   = CNT_W'(1);
            end
         end
         StRow2: begin
            if (!erase) begin
               if (row2_smp) begin
                  if (cnt_q < ROW_LEN) begin
                     wr_en   = 1'b1;
                     wr_addr = ROW2_BASE + PTR_W'(cnt_q);
                     cnt_d   = cnt_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (!adc && cnt_q < ROW_LEN) begin
                  err_d = 1'b1;
               end
            end
         end
         StDrain: begin
            if (xfer) rd_d = last_xfer ? '0 : rd_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= '0;
         rd_q         <= '0;
         exp_cnt_q    <= '0;
         exp_cycles_q <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         rd_q         <= rd_d;
         exp_cnt_q    <= exp_cnt_d;
         exp_cycles_q <= exp_cycles_d;
         err_q        <= err_d;
         done_q       <= done_d;
      end
   end

   // Frame buffer; contents are not reset.
   always_ff @(posedge clk) begin
      if (clr_buf) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= adc_data;
      end
   end

   // Stream outputs follow the read pointer for the whole drain phase.
   always_comb begin
      pix.pix_valid = (state_q == StDrain);
      pix.pix_data  = '0;
      pix.pix_last  = 1'b0;
      if (state_q == StDrain) begin
         pix.pix_data = mem_q[rd_q];
         pix.pix_last = (rd_q == LAST_PTR);
      end
   end

   assign exp_cycles = exp_cycles_q;
   assign frame_done = done_q;
   assign err        = err_q;
endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: frame-level model (expected pixel queue, exposure length, error flag)
// with a per-cycle stream checker.
module tb_pixel_readout;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned N      = 5;
   localparam int unsigned EXP_W  = 5;
   localparam int          EXP_MAX = 31;

   logic              clk = 1'b0;
   logic              reset;
   logic              erase, expose, nre1, nre2, adc;
   logic [DATA_W-1:0] adc_data;
   logic [EXP_W-1:0]  exp_cycles;
   logic              frame_done, err;

   pixel_readout_if #(.DATA_W(DATA_W)) pif ();

   pixel_readout #(.DATA_W(DATA_W), .NUM_SAMPLES(N), .EXP_W(EXP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .erase      (erase),
      .expose     (expose),
      .nre1       (nre1),
      .nre2       (nre2),
      .adc        (adc),
      .adc_data   (adc_data),
      .pix        (pif),
      .exp_cycles (exp_cycles),
      .frame_done (frame_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int exp_m = 0;
   bit err_m = 1'b0;
   int ready_mode = 0;
   int rcnt = 0;
   bit done_pend = 1'b0;
   bit prev_stall = 1'b0;
   int prev_data = 0;
   int prev_last = 0;

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Downstream ready: always, 1-0-0 pattern, or random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       pif.pix_ready = (rcnt % 3 == 0);
         2:       pif.pix_ready = 1'($urandom_range(0, 1));
         default: pif.pix_ready = 1'b1;
      endcase
      rcnt++;
   end

   // Stream checker against the expected pixel queue.
   always @(negedge clk) begin
      if (!reset) begin
         done_pend  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("frame_done", int'(frame_done), int'(done_pend));
         done_pend = 1'b0;
         if (exp_q.size() == 0) chk("valid_idle", int'(pif.pix_valid), 0);
         if (pif.pix_valid && exp_q.size() != 0) begin
            if (prev_stall) begin
               chk("stall_data", int'(pif.pix_data), prev_data);
               chk("stall_last", int'(pif.pix_last), prev_last);
            end
            if (pif.pix_ready) begin
               chk("pix_data", int'(pif.pix_data), exp_q[0]);
               chk("pix_last", int'(pif.pix_last), int'(exp_q.size() == 1));
               if (exp_q.size() == 1) done_pend = 1'b1;
               void'(exp_q.pop_front());
            end
         end
         prev_stall = pif.pix_valid && !pif.pix_ready;
         prev_data  = int'(pif.pix_data);
         prev_last  = int'(pif.pix_last);
      end
   end

   task automatic idle_inputs();
      erase = 1'b0; expose = 1'b0; nre1 = 1'b1; nre2 = 1'b1; adc = 1'b0; adc_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      exp_q.delete();
      err_m = 1'b0;
      exp_m = 0;
      reset = 1'b1;
      cyc();
   endtask

   task automatic push_seq(input int base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + i);
   endtask

   // viol bits: 0 both-nre-low in row 1, 1 stray adc between rows, 2 expose between rows,
   // 3 expose during drain. b1/b2 < 0 selects random data, else data = base + index.
   task automatic drive_frame(input int exp_len, input int n1, input int n2, input int viol,
                              input int abort_at, input int b1, input int b2, input bit lit,
                              input bit stop_mid);
      int r1[$];
      int r2[$];
      bit seen;
      for (int i = 0; i < n1; i++) r1.push_back(b1 < 0 ? int'($urandom_range(0, 255)) : b1 + i);
      for (int i = 0; i < n2; i++) r2.push_back(b2 < 0 ? int'($urandom_range(0, 255)) : b2 + i);
      expose = 1'b1;
      repeat (exp_len) cyc();
      expose = 1'b0;
      cyc();
      exp_m = (exp_len > EXP_MAX) ? EXP_MAX : exp_len;
      for (int i = 0; i < n1; i++) begin
         if (viol[0] && i == 1) begin
            nre1 = 1'b0; nre2 = 1'b0; adc = 1'b1; adc_data = 8'hEE;
            cyc();
            nre2 = 1'b1;
            err_m = 1'b1;
         end
         nre1 = 1'b0; adc = 1'b1; adc_data = 8'(r1[i]);
         if (i == abort_at) begin
            erase = 1'b1;
            cyc();
            idle_inputs();
            err_m = 1'b1;
            for (int k = 0; k < 6; k++) begin
               chk("abort_valid", int'(pif.pix_valid), 0);
               cyc();
            end
            chk("abort_err", int'(err), int'(err_m));
            chk("abort_exp", int'(exp_cycles), exp_m);
            return;
         end
         cyc();
      end
      adc = 1'b0; nre1 = 1'b1;
      cyc();
      if (n1 != N) err_m = 1'b1;
      if (viol[1]) begin
         adc = 1'b1;
         cyc();
         adc = 1'b0;
         err_m = 1'b1;
      end
      if (viol[2]) begin
         expose = 1'b1;
         cyc();
         expose = 1'b0;
         err_m = 1'b1;
      end
      cyc();
      for (int i = 0; i < n2; i++) begin
         nre2 = 1'b0; adc = 1'b1; adc_data = 8'(r2[i]);
         cyc();
      end
      adc = 1'b0; nre2 = 1'b1;
      if (n2 != N) err_m = 1'b1;
      if (!lit) begin
         for (int i = 0; i < 2 * N; i++) begin
            if (i < N) exp_q.push_back(i < n1 ? r1[i] : 0);
            else       exp_q.push_back(i - N < n2 ? r2[i - N] : 0);
         end
      end
      cyc();
      chk("latency", int'(pif.pix_valid), 1);
      if (stop_mid) begin
         repeat (3) cyc();
         chk("mid_exp", int'(exp_cycles), exp_m);
         chk("mid_err", int'(err), int'(err_m));
         reset = 1'b0;
         cyc();
         chk("rst_valid", int'(pif.pix_valid), 0);
         chk("rst_exp", int'(exp_cycles), 0);
         chk("rst_err", int'(err), 0);
         chk("rst_last", int'(pif.pix_last), 0);
         exp_q.delete();
         err_m = 1'b0;
         exp_m = 0;
         reset = 1'b1;
         cyc();
         return;
      end
      if (viol[3]) begin
         cyc();
         expose = 1'b1;
         cyc();
         expose = 1'b0;
         err_m = 1'b1;
      end
      seen = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("frame_done_seen", int'(seen), 1);
      chk("end_exp", int'(exp_cycles), exp_m);
      chk("end_err", int'(err), int'(err_m));
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      chk("reset_valid", int'(pif.pix_valid), 0);
      chk("reset_last", int'(pif.pix_last), 0);
      chk("reset_data", int'(pif.pix_data), 0);
      chk("reset_exp", int'(exp_cycles), 0);
      chk("reset_done", int'(frame_done), 0);
      chk("reset_err", int'(err), 0);
      reset = 1'b1;
      cyc();

      // Nominal frame.
      ready_mode = 0;
      push_seq(1, 10);
      drive_frame(15, 5, 5, 0, -1, 1, 6, 1'b1, 1'b0);
      chk("t1_exp", int'(exp_cycles), 15);
      chk("t1_err", int'(err), 0);

      // Backpressure 1,0,0.
      do_reset();
      ready_mode = 1;
      push_seq(1, 10);
      drive_frame(15, 5, 5, 0, -1, 1, 6, 1'b1, 1'b0);
      chk("t2_err", int'(err), 0);

      // Short row 1, long row 2.
      do_reset();
      ready_mode = 0;
      push_seq(161, 3);
      push_seq(0, 1);
      exp_q.push_back(0);
      push_seq(97, 5);
      drive_frame(10, 3, 7, 0, -1, 161, 97, 1'b1, 1'b0);
      chk("t3_err", int'(err), 1);

      // Both row selects low: flagged, not stored.
      do_reset();
      push_seq(1, 10);
      drive_frame(8, 5, 5, 1, -1, 1, 6, 1'b1, 1'b0);
      chk("t4_err", int'(err), 1);

      // Erase during row 1.
      do_reset();
      drive_frame(8, 5, 5, 0, 2, 1, 6, 1'b1, 1'b0);
      chk("t4b_err", int'(err), 1);

      // Saturation, then reset mid-drain after a short row.
      do_reset();
      push_seq(1, 10);
      drive_frame(40, 5, 5, 0, -1, 1, 6, 1'b1, 1'b0);
      chk("t5_exp", int'(exp_cycles), 31);
      push_seq(1, 3);
      push_seq(0, 1);
      exp_q.push_back(0);
      push_seq(6, 5);
      drive_frame(12, 3, 5, 0, -1, 1, 6, 1'b1, 1'b1);

      // Expose during drain is ignored; next frame after frame_done is captured.
      do_reset();
      ready_mode = 2;
      push_seq(1, 10);
      drive_frame(5, 5, 5, 8, -1, 1, 6, 1'b1, 1'b0);
      chk("t6_err", int'(err), 1);
      push_seq(11, 10);
      drive_frame(6, 5, 5, 0, -1, 11, 16, 1'b1, 1'b0);
      chk("t6_exp", int'(exp_cycles), 6);

      // Randomized frames.
      for (int f = 0; f < 25; f++) begin
         int n1;
         int n2;
         int ab;
         if ($urandom_range(0, 2) == 0) do_reset();
         ready_mode = int'($urandom_range(0, 2));
         n1 = int'($urandom_range(1, 8));
         n2 = int'($urandom_range(1, 8));
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n1 - 1)) : -1;
         drive_frame(int'($urandom_range(1, 40)), n1, n2, int'($urandom_range(0, 15)), ab,
                     -1, -1, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
